// File: rtl/tft_pkg.sv
// Shared types and helpers for the TFT framebuffer fetch path.
// Provides the fetch FSM state type and the buffer base address helper.
package tft_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DONE
    } fetch_state_t;

    // Word address of framebuffer idx: base + idx*stride.
    function automatic logic [63:0] buf_addr(
        input logic [63:0] base,
        input logic [63:0] stride,
        input logic [63:0] idx
    );
        return base + idx * stride;
    endfunction

endpackage

// File: rtl/tft_fetch_tgl_sync.sv
// Toggle synchroniser: 2-flop sync of tgl_in plus edge detector.
// Ports: clkSYS, aclr (async, active-high), tgl_in (foreign domain), pulse (1 cycle).
module tgl_sync (
    input  logic clkSYS,
    input  logic aclr,
    input  logic tgl_in,
    output logic pulse
);

    // sh[1:0] is the synchroniser, sh[2] remembers the last synced level.
    logic [2:0] sh;

    always_ff @(posedge clkSYS or posedge aclr) begin
        if (aclr) begin
            sh <= '0;
        end else begin
            sh <= {sh[1:0], tgl_in};
        end
    end

    assign pulse = sh[2] ^ sh[1];

endmodule

// File: rtl/tft_fetch.sv
// Framebuffer fetch engine: bursts over one of NBUF buffers, metered by FIFO credits.
// Ports: clkSYS/aclr; frame_start, buf_sel/buf_stat, drain_tgl, req/req_addr/req_ack,
// mem_valid/fifo_wrreq, level, busy, err_cnt. Macro TFT_FETCH_ERR_EN enables err_cnt.
module tft_fetch
    import tft_pkg::*;
#(
    parameter int          AN     = 24,
    parameter int          BURST  = 8,
    parameter int          DEPTH  = 64,
    parameter int          NBUF   = 2,
    parameter int unsigned BASE   = 0,
    parameter int unsigned STRIDE = 'h20000,
    parameter int          NBURST = 16320,
    localparam int         SB     = (NBUF > 1) ? $clog2(NBUF) : 1,
    localparam int         LW     = $clog2(DEPTH) + 1
) (
    input  logic          clkSYS,
    input  logic          aclr,
    input  logic          frame_start,
    input  logic [SB-1:0] buf_sel,
    output logic [SB-1:0] buf_stat,
    input  logic          drain_tgl,
    output logic          req,
    output logic [AN-1:0] req_addr,
    input  logic          req_ack,
    input  logic          mem_valid,
    output logic          fifo_wrreq,
    output logic [LW-1:0] level,
    output logic          busy,
    output logic [7:0]    err_cnt
);

    localparam int LFW = $clog2(NBURST + 1);

    fetch_state_t   state;
    logic [LFW-1:0] left;
    logic [SB-1:0]  sel;
    logic           drain;
    logic           ack;
    logic           last;
    logic           req_nx;
    logic [LW-1:0]  level_nx;

    tgl_sync u_sync (
        .clkSYS (clkSYS),
        .aclr   (aclr),
        .tgl_in (drain_tgl),
        .pulse  (drain)
    );

    assign sel = (int'(buf_sel) >= NBUF) ? SB'(NBUF - 1) : buf_sel;

    assign ack  = req && req_ack;
    assign last = ack && (left == LFW'(1));

    // A simultaneous ack and drain cancel; a drain on an empty FIFO is lost.
    always_comb begin
        level_nx = level;
        if (frame_start) begin
            level_nx = '0;
        end else if (ack && !drain) begin
            level_nx = level + LW'(BURST);
        end else if (drain && !ack && (level != '0)) begin
            level_nx = level - LW'(BURST);
        end
    end

    // Request only while room remains for a full burst after this cycle's update.
    assign req_nx = (state == FETCH) && !last && (left != '0)
                  && (int'(level_nx) + BURST <= DEPTH);

    always_ff @(posedge clkSYS or posedge aclr) begin
        if (aclr) begin
            level <= '0;
        end else begin
            level <= level_nx;
        end
    end

    always_ff @(posedge clkSYS or posedge aclr) begin
        if (aclr) begin
            state    <= IDLE;
            req      <= 1'b0;
            req_addr <= AN'(BASE);
            buf_stat <= '0;
            left     <= '0;
        end else if (frame_start) begin
            state    <= FETCH;
            req      <= 1'b0;
            buf_stat <= sel;
            req_addr <= AN'(buf_addr(64'(BASE), 64'(STRIDE), 64'(sel)));
            left     <= LFW'(NBURST);
        end else begin
            req <= req_nx;
            if (ack) begin
                req_addr <= req_addr + AN'(BURST);
                left     <= left - LFW'(1);
                if (last) begin
                    state <= DONE;
                end
            end
        end
    end

    assign fifo_wrreq = mem_valid && (state != IDLE);
    assign busy       = (state == FETCH);

`ifdef TFT_FETCH_ERR_EN
    logic       underrun;
    logic       late;
    logic [8:0] err_sum;

    assign underrun = drain && !ack && !frame_start && (level == '0);
    assign late     = frame_start && (state == FETCH);
    assign err_sum  = {1'b0, err_cnt} + 9'(underrun) + 9'(late);

    always_ff @(posedge clkSYS or posedge aclr) begin
        if (aclr) begin
            err_cnt <= '0;
        end else begin
            err_cnt <= err_sum[8] ? 8'hFF : err_sum[7:0];
        end
    end
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_tft_fetch.sv
// Self-checking bench for tft_fetch: expected burst addresses queued per frame,
// popped and compared on every ack; level/state/error checks at key points.
module tb_tft_fetch;

    localparam int AN     = 24;
    localparam int NB     = 12;
    localparam int BURST  = 8;
    localparam int STRIDE = 'h20000;

`ifdef TFT_FETCH_ERR_EN
    localparam int E_UNDER = 1;
    localparam int E_LATE  = 2;
`else
    localparam int E_UNDER = 0;
    localparam int E_LATE  = 0;
`endif

    logic          clkSYS = 1'b0;
    logic          aclr = 1'b1;
    logic          frame_start = 1'b0;
    logic [1:0]    buf_sel = '0;
    logic [1:0]    buf_stat;
    logic          drain_tgl = 1'b0;
    logic          req;
    logic [AN-1:0] req_addr;
    logic          req_ack = 1'b0;
    logic          mem_valid = 1'b0;
    logic          fifo_wrreq;
    logic [6:0]    level;
    logic          busy;
    logic [7:0]    err_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int n_ack = 0;
    logic [AN-1:0] exp_q[$];

    always #5 clkSYS = ~clkSYS;

    tft_fetch #(
        .AN     (AN),
        .BURST  (BURST),
        .DEPTH  (64),
        .NBUF   (3),
        .BASE   (0),
        .STRIDE (STRIDE),
        .NBURST (NB)
    ) dut (
        .clkSYS      (clkSYS),
        .aclr        (aclr),
        .frame_start (frame_start),
        .buf_sel     (buf_sel),
        .buf_stat    (buf_stat),
        .drain_tgl   (drain_tgl),
        .req         (req),
        .req_addr    (req_addr),
        .req_ack     (req_ack),
        .mem_valid   (mem_valid),
        .fifo_wrreq  (fifo_wrreq),
        .level       (level),
        .busy        (busy),
        .err_cnt     (err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 'h%0h want 'h%0h", tag, got, exp);
        end
    endtask

    // One clock; acks a pending request when ack_en and checks its address.
    task automatic tick(input bit ack_en);
        req_ack = ack_en && req;
        if (req_ack) begin
            n_ack++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_empty: ack at 'h%0h with nothing expected",
                         req_addr);
            end else begin
                chk("addr", 32'(req_addr), 32'(exp_q.pop_front()));
            end
        end
        @(posedge clkSYS);
        #1;
        req_ack     = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic start_frame(input logic [1:0] sel,
                               input logic [AN-1:0] base);
        exp_q.delete();
        for (int i = 0; i < NB; i++) begin
            exp_q.push_back(base + AN'(i * BURST));
        end
        buf_sel     = sel;
        frame_start = 1'b1;
        tick(1'b0);
    endtask

    initial begin
        repeat (3) @(posedge clkSYS);
        #1;
        mem_valid = 1'b1;
        chk("rst_req", 32'(req), 0);
        chk("rst_addr", 32'(req_addr), 0);
        chk("rst_stat", 32'(buf_stat), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err_cnt), 0);
        chk("rst_wr", 32'(fifo_wrreq), 0);
        aclr = 1'b0;
        tick(1'b0);
        tick(1'b0);

        start_frame(2'd1, AN'(STRIDE));
        chk("t2_busy", 32'(busy), 1);
        chk("t2_stat", 32'(buf_stat), 1);
        chk("t2_req0", 32'(req), 0);
        n_ack = 0;
        repeat (20) tick(1'b1);
        chk("t2_acks", n_ack, 8);
        chk("t2_level", 32'(level), 64);
        chk("t2_req_full", 32'(req), 0);
        chk("t2_left", exp_q.size(), NB - 8);

        req_ack = 1'b1;
        @(posedge clkSYS);
        #1;
        req_ack = 1'b0;
        chk("stray_level", 32'(level), 64);
        chk("stray_addr", 32'(req_addr), STRIDE + 64);

        drain_tgl = ~drain_tgl;
        tick(1'b0);
        tick(1'b0);
        chk("t3_early", 32'(level), 64);
        tick(1'b0);
        chk("t3_level", 32'(level), 56);
        chk("t3_req", 32'(req), 1);

        drain_tgl = ~drain_tgl;
        tick(1'b0);
        tick(1'b0);
        tick(1'b1);
        chk("t4_ackdrain", 32'(level), 56);
        chk("t4_req", 32'(req), 1);

        for (int i = 0; i < 60 && busy; i++) begin
            if (i % 4 == 0) drain_tgl = ~drain_tgl;
            tick(1'b1);
        end
        chk("t4_busy", 32'(busy), 0);
        chk("t4_req_done", 32'(req), 0);
        chk("t4_acks", n_ack, NB);
        chk("t4_sb_empty", exp_q.size(), 0);
        chk("t4_level", 32'(level), 64);
        chk("t4_wr_done", 32'(fifo_wrreq), 1);
        repeat (3) tick(1'b0);
        chk("t4_req_hold", 32'(req), 0);

        start_frame(2'd0, '0);
        chk("t5_level0", 32'(level), 0);
        chk("t5_busy", 32'(busy), 1);
        chk("t5_err_pre", 32'(err_cnt), 0);
        drain_tgl = ~drain_tgl;
        repeat (3) tick(1'b0);
        chk("t5_underrun", 32'(level), 0);
        chk("t5_err", 32'(err_cnt), E_UNDER);

        drain_tgl = ~drain_tgl;
        tick(1'b0);
        tick(1'b0);
        start_frame(2'd3, AN'(2 * STRIDE));
        chk("t6_clamp", 32'(buf_stat), 2);
        chk("t6_level", 32'(level), 0);
        chk("t6_err", 32'(err_cnt), E_LATE);
        n_ack = 0;
        for (int i = 0; i < 10 && n_ack < 2; i++) tick(1'b1);
        chk("t6_acks", n_ack, 2);
        chk("t6_level2", 32'(level), 16);

        aclr = 1'b1;
        @(posedge clkSYS);
        #1;
        chk("t1_req", 32'(req), 0);
        chk("t1_level", 32'(level), 0);
        chk("t1_addr", 32'(req_addr), 0);
        chk("t1_busy", 32'(busy), 0);
        chk("t1_err", 32'(err_cnt), 0);
        chk("t1_wr", 32'(fifo_wrreq), 0);
        aclr = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
